// File: rtl/cam_manager.sv
// cam_manager: command front end for the shift-register CAM.
// Accepts key-based LOOKUP / INSERT / DELETE commands, drives the CAM compare
// and write ports, tracks row occupancy in a bitmap, allocates the lowest free
// row on insert, refuses duplicate keys, and returns one status response per
// accepted command.
//
// state        | meaning
// -------------+------------------------------------------------------------
// IDLE         | ready for a command once the CAM is not busy
// LOOKUP_WAIT  | compare key presented; CAM registers its match this cycle
// LOOKUP       | match result sampled, command resolved or write target chosen
// ISSUE        | one-cycle CAM write pulse; bitmap and entry count updated
// BUSY_WAIT    | CAM performing the write; first cycle ignores write_busy
// RESP         | response held until rsp_ready
module cam_manager #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] cmd_key,
    input  logic [1:0]            cmd_op,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic [1:0]            rsp_status,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ADDR_WIDTH:0]   entry_count,
    output logic                  full,
    output logic [ADDR_WIDTH-1:0] cam_write_addr,
    output logic [DATA_WIDTH-1:0] cam_write_data,
    output logic                  cam_write_delete,
    output logic                  cam_write_enable,
    input  logic                  cam_write_busy,
    output logic [DATA_WIDTH-1:0] cam_compare_data,
    input  logic                  cam_match,
    input  logic [ADDR_WIDTH-1:0] cam_match_addr
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [1:0] OP_INSERT = 2'd1;
    localparam logic [1:0] OP_DELETE = 2'd2;

    localparam logic [1:0] RSP_OK        = 2'd0;
    localparam logic [1:0] RSP_EXISTS    = 2'd1;
    localparam logic [1:0] RSP_FULL      = 2'd2;
    localparam logic [1:0] RSP_NOT_FOUND = 2'd3;

    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] CNT_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP_WAIT,
        ST_LOOKUP,
        ST_ISSUE,
        ST_BUSY_WAIT,
        ST_RESP
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic [DATA_WIDTH-1:0]   key_q;
    logic                    is_insert_q;
    logic                    is_delete_q;
    logic [ADDR_WIDTH-1:0]   target_q;
    logic [DEPTH-1:0]        bitmap;
    logic                    busy_armed_q;

    logic                    cmd_accept;
    logic [ADDR_WIDTH-1:0]   free_idx;
    logic                    lk_to_issue;
    logic [1:0]              lk_status;
    logic [ADDR_WIDTH-1:0]   lk_addr;
    logic [ADDR_WIDTH:0]     count_nxt;

    assign cmd_accept = cmd_valid && cmd_ready;

    // Lowest row whose bitmap bit is clear; only meaningful when not full.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!bitmap[i]) begin
                free_idx = ADDR_WIDTH'(i);
            end
        end
    end

    // Resolve the command from the sampled CAM match result.
    // Reserved opcode 3 falls through to the lookup branch.
    always_comb begin
        lk_to_issue = 1'b0;
        lk_status   = RSP_NOT_FOUND;
        lk_addr     = '0;
        if (is_insert_q) begin
            if (cam_match) begin
                lk_status = RSP_EXISTS;
                lk_addr   = cam_match_addr;
            end else if (full) begin
                lk_status = RSP_FULL;
            end else begin
                lk_to_issue = 1'b1;
                lk_status   = RSP_OK;
                lk_addr     = free_idx;
            end
        end else if (is_delete_q) begin
            if (cam_match) begin
                lk_to_issue = 1'b1;
                lk_status   = RSP_OK;
                lk_addr     = cam_match_addr;
            end
        end else begin
            if (cam_match) begin
                lk_status = RSP_OK;
                lk_addr   = cam_match_addr;
            end
        end
    end

    // Occupancy after the write performed in ISSUE.
    always_comb begin
        if (is_insert_q) begin
            count_nxt = entry_count + CNT_ONE;
        end else begin
            count_nxt = entry_count - CNT_ONE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cmd_accept) begin
                    state_nxt = ST_LOOKUP_WAIT;
                end
            end
            ST_LOOKUP_WAIT: begin
                state_nxt = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                state_nxt = lk_to_issue ? ST_ISSUE : ST_RESP;
            end
            ST_ISSUE: begin
                state_nxt = ST_BUSY_WAIT;
            end
            ST_BUSY_WAIT: begin
                if (busy_armed_q && !cam_write_busy) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM outputs; the write port is only live during ISSUE.
    always_comb begin
        cmd_ready        = (state == ST_IDLE) && !cam_write_busy;
        rsp_valid        = (state == ST_RESP);
        cam_write_enable = (state == ST_ISSUE);
        cam_write_delete = (state == ST_ISSUE) && is_delete_q;
        cam_write_addr   = target_q;
        cam_write_data   = key_q;
    end

    // Command latch, response registers, occupancy bitmap and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q            <= '0;
            is_insert_q      <= 1'b0;
            is_delete_q      <= 1'b0;
            target_q         <= '0;
            bitmap           <= '0;
            busy_armed_q     <= 1'b0;
            entry_count      <= '0;
            full             <= 1'b0;
            rsp_status       <= RSP_OK;
            rsp_addr         <= '0;
            cam_compare_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_accept) begin
                        key_q            <= cmd_key;
                        is_insert_q      <= (cmd_op == OP_INSERT);
                        is_delete_q      <= (cmd_op == OP_DELETE);
                        cam_compare_data <= cmd_key;
                    end
                end
                ST_LOOKUP: begin
                    if (lk_to_issue) begin
                        target_q <= lk_addr;
                    end else begin
                        rsp_status <= lk_status;
                        rsp_addr   <= lk_addr;
                    end
                end
                ST_ISSUE: begin
                    bitmap[target_q] <= is_insert_q;
                    entry_count      <= count_nxt;
                    full             <= (count_nxt == CNT_DEPTH);
                    rsp_status       <= RSP_OK;
                    rsp_addr         <= target_q;
                    busy_armed_q     <= 1'b0;
                end
                ST_BUSY_WAIT: begin
                    busy_armed_q <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_manager.sv
// Bench for cam_manager: a behavioural CAM with init/write busy windows, a
// key/row table reference model, directed scenarios and randomized commands.
module tb_cam_manager;

    localparam int DW    = 16;
    localparam int AW    = 2;
    localparam int DEPTH = 2 ** AW;
    localparam int CAM_BUSY = 16;

    localparam logic [1:0] S_OK = 2'd0, S_EXISTS = 2'd1, S_FULL = 2'd2, S_NF = 2'd3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] cmd_key = '0;
    logic [1:0]    cmd_op = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    rsp_status;
    logic [AW-1:0] rsp_addr;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [AW:0]   entry_count;
    logic          full;
    logic [AW-1:0] cam_write_addr;
    logic [DW-1:0] cam_write_data;
    logic          cam_write_delete;
    logic          cam_write_enable;
    logic          cam_write_busy;
    logic [DW-1:0] cam_compare_data;
    logic          cam_match;
    logic [AW-1:0] cam_match_addr;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    cam_manager #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_key(cmd_key), .cmd_op(cmd_op), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .rsp_status(rsp_status), .rsp_addr(rsp_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .entry_count(entry_count), .full(full),
        .cam_write_addr(cam_write_addr), .cam_write_data(cam_write_data),
        .cam_write_delete(cam_write_delete), .cam_write_enable(cam_write_enable),
        .cam_write_busy(cam_write_busy), .cam_compare_data(cam_compare_data),
        .cam_match(cam_match), .cam_match_addr(cam_match_addr)
    );

    // Behavioural CAM: registered match, busy for a fixed window after reset and after each write.
    logic [DW-1:0] cmem [DEPTH];
    logic          cvld [DEPTH];
    int            busy_cnt;
    logic          m_hit;
    logic [AW-1:0] m_addr;

    assign cam_write_busy = (busy_cnt != 0);

    always_comb begin
        m_hit  = 1'b0;
        m_addr = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (cvld[i] && cmem[i] == cam_compare_data) begin
                m_hit  = 1'b1;
                m_addr = AW'(i);
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                cvld[i] <= 1'b0;
                cmem[i] <= '0;
            end
            busy_cnt       <= CAM_BUSY;
            cam_match      <= 1'b0;
            cam_match_addr <= '0;
        end else begin
            cam_match      <= m_hit;
            cam_match_addr <= m_addr;
            if (cam_write_enable) begin
                busy_cnt <= CAM_BUSY;
                cvld[cam_write_addr] <= !cam_write_delete;
                cmem[cam_write_addr] <= cam_write_data;
            end else if (busy_cnt > 0) begin
                busy_cnt <= busy_cnt - 1;
            end
        end
    end

    // Reference model: which key lives in which row.
    logic [DW-1:0] ref_key [DEPTH];
    bit            ref_vld [DEPTH];

    function automatic int ref_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) if (ref_vld[i]) c++;
        return c;
    endfunction

    task automatic ref_clear();
        for (int i = 0; i < DEPTH; i++) begin
            ref_vld[i] = 1'b0;
            ref_key[i] = '0;
        end
    endtask

    task automatic model_cmd(input logic [1:0] op, input logic [DW-1:0] key,
                             output logic [1:0] st, output logic [AW-1:0] ad, output bit wr);
        int hit = -1;
        int fr  = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (ref_vld[i] && ref_key[i] == key && hit < 0) hit = i;
            if (!ref_vld[i] && fr < 0) fr = i;
        end
        wr = 1'b0;
        st = S_NF;
        ad = '0;
        if (op == 2'd1) begin
            if (hit >= 0) begin
                st = S_EXISTS;
                ad = AW'(hit);
            end else if (ref_count() == DEPTH) begin
                st = S_FULL;
            end else begin
                st = S_OK;
                ad = AW'(fr);
                wr = 1'b1;
                ref_vld[fr] = 1'b1;
                ref_key[fr] = key;
            end
        end else if (op == 2'd2) begin
            if (hit >= 0) begin
                st = S_OK;
                ad = AW'(hit);
                wr = 1'b1;
                ref_vld[hit] = 1'b0;
            end
        end else if (hit >= 0) begin
            st = S_OK;
            ad = AW'(hit);
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_ready(output bit ok);
        int t = 0;
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        ok = cmd_ready;
    endtask

    // Issue one command and check latency, write-port activity and the response.
    task automatic run_cmd(input logic [1:0] op, input logic [DW-1:0] key, input int hold);
        logic [1:0]    est;
        logic [AW-1:0] ead;
        bit            ewr, ok, seen;
        int            n, en_cnt, en_at;
        @(negedge clk);
        cmd_op = op;
        cmd_key = key;
        cmd_valid = 1'b1;
        wait_ready(ok);
        if (!ok) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_key = DW'($urandom);
        model_cmd(op, key, est, ead, ewr);
        n = 0; en_cnt = 0; en_at = 0; seen = 1'b0;
        while (n < 60 && !seen) begin
            @(negedge clk);
            n++;
            if (cam_write_enable) begin
                en_cnt++;
                en_at = n;
                chk("wr_addr", cam_write_addr, ead);
                chk("wr_data", cam_write_data, key);
                chk("wr_delete", cam_write_delete, op == 2'd2);
            end
            if (rsp_valid) seen = 1'b1;
        end
        chk("rsp_seen", seen, 1);
        if (!seen) return;
        chk("rsp_latency", n, ewr ? 21 : 3);
        chk("wr_pulses", en_cnt, ewr);
        if (ewr) chk("wr_cycle", en_at, 3);
        chk("rsp_status", rsp_status, est);
        chk("rsp_addr", rsp_addr, ead);
        chk("entry_count", entry_count, ref_count());
        chk("full", full, ref_count() == DEPTH);
        // A decoy command held during RESP must not be taken.
        cmd_op = 2'd1;
        cmd_key = key ^ 16'h5a5a;
        cmd_valid = 1'b1;
        repeat (hold) begin
            chk("hold_cmd_ready", cmd_ready, 0);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_status", rsp_status, est);
            chk("hold_addr", rsp_addr, ead);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rsp_dropped", rsp_valid, 0);
        chk("ready_after_rsp", cmd_ready, 1);
        chk("decoy_ignored", cam_compare_data, key);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_status"}, rsp_status, 0);
        chk({tag, "_rsp_addr"}, rsp_addr, 0);
        chk({tag, "_entry_count"}, entry_count, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_wr_en"}, cam_write_enable, 0);
        chk({tag, "_wr_addr"}, cam_write_addr, 0);
        chk({tag, "_wr_data"}, cam_write_data, 0);
        chk({tag, "_wr_del"}, cam_write_delete, 0);
        chk({tag, "_cmp_data"}, cam_compare_data, 0);
    endtask

    task automatic release_and_init(input string tag);
        int  t = 0;
        bit  stray = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk({tag, "_busy_blocks_ready"}, cmd_ready, 0);
        while (!cmd_ready && t < 100) begin
            if (rsp_valid) stray = 1'b1;
            @(negedge clk);
            t++;
        end
        chk({tag, "_ready_after_init"}, cmd_ready, 1);
        chk({tag, "_no_stray_rsp"}, stray, 0);
        chk({tag, "_count_after_init"}, entry_count, 0);
    endtask

    initial begin
        bit ok;
        ref_clear();
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("rst");
        release_and_init("init");

        run_cmd(2'd0, 16'h1234, 0);
        run_cmd(2'd1, 16'h000A, 0);
        run_cmd(2'd1, 16'h000B, 0);
        run_cmd(2'd1, 16'h000C, 0);
        run_cmd(2'd0, 16'h000B, 0);
        run_cmd(2'd1, 16'h000B, 0);
        run_cmd(2'd2, 16'h000B, 0);
        run_cmd(2'd0, 16'h000B, 0);
        run_cmd(2'd1, 16'h000D, 10);
        run_cmd(2'd1, 16'h000E, 0);
        run_cmd(2'd1, 16'h000F, 0);
        run_cmd(2'd2, 16'h0077, 0);
        run_cmd(2'd3, 16'h000E, 2);

        // Reset asserted while the CAM write of a DELETE is in flight.
        @(negedge clk);
        cmd_op = 2'd2;
        cmd_key = 16'h000A;
        cmd_valid = 1'b1;
        wait_ready(ok);
        chk("midrst_accept", ok, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        ref_clear();
        repeat (3) @(negedge clk);
        chk("midrst_no_rsp", rsp_valid, 0);
        release_and_init("reinit");
        run_cmd(2'd0, 16'h000A, 0);

        for (int k = 0; k < 120; k++) begin
            int r;
            logic [1:0] op;
            r = $urandom_range(0, 9);
            op = (r < 4) ? 2'd1 : (r < 7) ? 2'd2 : (r < 9) ? 2'd0 : 2'd3;
            run_cmd(op, DW'($urandom_range(1, 6)), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
